multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Next-generation MIPS control unit for the multicycle datapath: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks instead of one combinational decode.
- Adds a memory ready handshake, a wait-state watchdog, optional bne support, illegal-opcode detection and a retired-instruction counter.
- Sits between the instruction register opcode field and the multicycle datapath muxes, register file, ALU decoder and memory.

Parameters:
- SUPPORT_BNE, 1, 1 = opcode 000101 executes as bne; 0 = treated as illegal
- MAX_WAIT, 15, maximum cycles in one memory state before abort; 0 disables the watchdog
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26] from IR; integrator holds it stable from DECODE until return to FETCH
- mem_ready  in  1  memory completes the current access this cycle
- IorD  out  1  memory address select, 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- PCWrite  out  1  unconditional PC write
- Branch  out  1  PC write if zero (beq)
- BranchNe  out  1  PC write if not zero (bne)
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUOp  out  2  00 add, 01 sub, 10 funct, 11 immediate-decode
- ALUSrcA  out  1  0=PC, 1=rs register
- ALUSrcB  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
- RegDst  out  1  1=rd, 0=rt
- MemtoReg  out  1  1=MDR, 0=ALUOut
- RegWrite  out  1  register file write
- state  out  4  current state code, for debug
- instr_done  out  1  one-cycle pulse on the final cycle of each retired instruction
- retired  out  CNT_W  count of retired instructions, wraps modulo 2^CNT_W
- illegal  out  1  sticky flag: unsupported opcode decoded
- mem_timeout  out  1  sticky flag: watchdog abort occurred

Behaviour:
- Reset, asynchronous: state=FETCH(0); retired=0; illegal=0; mem_timeout=0; wait counter=0.
  - While reset is high, outputs equal FETCH decode except IRWrite=PCWrite=0.
- All control outputs are Moore decodes of state, except IRWrite and PCWrite in FETCH, which also require mem_ready. Any output not listed for a state is 0.
- States, outputs and next state:
  - 0 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=PCWrite=mem_ready. Next: mem_ready ? DECODE : FETCH.
  - 1 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next by opcode:
    - 000000 -> EXEC
    - 100011 or 101011 -> MEMADR
    - 000100 -> BRANCH; 000101 -> BRANCH if SUPPORT_BNE
    - 000010 -> JUMP
    - 001000/001001/001010/001100/001101/001110/001111 -> IMMEXEC
    - any other opcode -> FETCH with illegal set; no instr_done, no retired increment
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw -> MEMRD, sw -> MEMWR.
  - 3 MEMRD: IorD=1, MemRead=1. Next: mem_ready ? MEMWB : MEMRD.
  - 4 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH; instr_done.
  - 5 MEMWR: IorD=1, MemWrite=1. Next: mem_ready ? FETCH with instr_done : MEMWR.
  - 6 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - 7 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH; instr_done.
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01; Branch=1 for 000100, BranchNe=1 for 000101. Next: FETCH; instr_done.
  - 9 IMMEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Next: IMMWB.
  - 10 IMMWB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH; instr_done.
  - 11 JUMP: PCSrc=10, PCWrite=1. Next: FETCH; instr_done.
  - Codes 12-15: unreachable; if entered, next state is FETCH, all outputs 0.
- Latency with mem_ready tied 1: lw 5 cycles; sw, R-type and I-type ALU 4; beq, bne and j 3.
- Watchdog, applies to FETCH, MEMRD and MEMWR:
  - Wait counter clears on entry to a memory state.
  - Counter increments each cycle in that state with mem_ready=0.
  - If mem_ready=0 and counter==MAX_WAIT-1: next state FETCH, mem_timeout<=1, no instr_done, no retired increment.
  - A memory state therefore lasts at most MAX_WAIT cycles.
  - mem_ready=1 in the abort cycle wins: normal completion.
  - Abort from FETCH re-enters FETCH with the counter cleared.
- retired increments on every instr_done cycle; it wraps from all-ones to 0 with no flag.
- Sticky flags clear only on reset.

Test Plan:
- Reset then mem_ready=1, opcode=100011 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; instr_done at cycle 5; retired=1.
- opcode=000101, SUPPORT_BNE=1 -> 0,1,8 with BranchNe=1, ALUOp=01, PCSrc=01. With SUPPORT_BNE=0 -> 0,1,0 with illegal=1 and retired unchanged.
- sw with mem_ready low for 3 cycles in MEMWR, MAX_WAIT=15 -> MemWrite held 4 cycles; instr_done on the mem_ready cycle; mem_timeout=0.
- MAX_WAIT=4, lw with mem_ready stuck 0 in MEMRD -> after 4 cycles in state 3, state=0; mem_timeout=1; RegWrite never asserted.
- Back-to-back R-type (000000), j (000010) and ori (001101) -> state sequence 0,1,6,7,0,1,11,0,1,9,10; PCWrite=1 in state 11; retired=3.
- Assert reset in state 3 mid-lw -> state=0 immediately, before the clock; retired=0; flags=0; IRWrite=0 while reset is high.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : multicycle_control_fsm                                            |
// | Desc   : Moore control FSM for a MIPS multicycle datapath with memory      |
// |          handshake, wait-state watchdog and retired-instruction counter.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module multicycle_control_fsm #(
  parameter bit SUPPORT_BNE = 1'b1,
  parameter int MAX_WAIT    = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic             BranchNe,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic             mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic               done_d;
  logic               mem_state, wd_expire;

  // Registered Moore outputs, decoded from the next state
  logic       fetch_q, fetch_d;
  logic       iord_q, iord_d;
  logic       memread_q, memread_d;
  logic       memwrite_q, memwrite_d;
  logic       jumpwr_q, jumpwr_d;
  logic       branch_q, branch_d;
  logic       branchne_q, branchne_d;
  logic [1:0] pcsrc_q, pcsrc_d;
  logic [1:0] aluop_q, aluop_d;
  logic       alusrca_q, alusrca_d;
  logic [1:0] alusrcb_q, alusrcb_d;
  logic       regdst_q, regdst_d;
  logic       memtoreg_q, memtoreg_d;
  logic       regwrite_q, regwrite_d;

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    wd_expire = (MAX_WAIT != 0) && mem_state && !mem_ready && (wait_q == WAIT_LAST);

    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                 state_d = S_EXEC;
          6'b100011, OP_SW:         state_d = S_MEMADR;
          OP_BEQ:                   state_d = S_BRANCH;
          6'b000010:                state_d = S_JUMP;
          6'b001000, 6'b001001, 6'b001010, 6'b001100,
          6'b001101, 6'b001110, 6'b001111:
                                    state_d = S_IMMEXEC;
          OP_BNE: begin
            if (SUPPORT_BNE) begin
              state_d = S_BRANCH;
            end else begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   begin state_d = S_FETCH; done_d = 1'b1; end
      S_MEMWR:   if (mem_ready) begin state_d = S_FETCH; done_d = 1'b1; end
      S_EXEC:    state_d = S_ALUWB;
      S_ALUWB:   begin state_d = S_FETCH; done_d = 1'b1; end
      S_BRANCH:  begin state_d = S_FETCH; done_d = 1'b1; end
      S_IMMEXEC: state_d = S_IMMWB;
      S_IMMWB:   begin state_d = S_FETCH; done_d = 1'b1; end
      S_JUMP:    begin state_d = S_FETCH; done_d = 1'b1; end
      default:   state_d = S_FETCH;
    endcase

    if (wd_expire) begin
      state_d   = S_FETCH;
      timeout_d = 1'b1;
    end

    // Staying in a memory state implies mem_ready was low; any move or abort restarts the count
    wait_d    = (mem_state && (state_d == state_q) && !wd_expire) ? wait_q + WAIT_W'(1) : '0;
    retired_d = retired_q + CNT_W'(done_d);

    fetch_d    = 1'b0;
    iord_d     = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    jumpwr_d   = 1'b0;
    branch_d   = 1'b0;
    branchne_d = 1'b0;
    pcsrc_d    = 2'b00;
    aluop_d    = 2'b00;
    alusrca_d  = 1'b0;
    alusrcb_d  = 2'b00;
    regdst_d   = 1'b0;
    memtoreg_d = 1'b0;
    regwrite_d = 1'b0;
    case (state_d)
      S_FETCH:   begin fetch_d = 1'b1; memread_d = 1'b1; alusrcb_d = 2'b01; end
      S_DECODE:  alusrcb_d = 2'b11;
      S_MEMADR:  begin alusrca_d = 1'b1; alusrcb_d = 2'b10; end
      S_MEMRD:   begin iord_d = 1'b1; memread_d = 1'b1; end
      S_MEMWB:   begin memtoreg_d = 1'b1; regwrite_d = 1'b1; end
      S_MEMWR:   begin iord_d = 1'b1; memwrite_d = 1'b1; end
      S_EXEC:    begin alusrca_d = 1'b1; aluop_d = 2'b10; end
      S_ALUWB:   begin regdst_d = 1'b1; regwrite_d = 1'b1; end
      S_BRANCH: begin
        alusrca_d  = 1'b1;
        aluop_d    = 2'b01;
        pcsrc_d    = 2'b01;
        branch_d   = (opcode == OP_BEQ);
        branchne_d = (opcode == OP_BNE);
      end
      S_IMMEXEC: begin alusrca_d = 1'b1; alusrcb_d = 2'b10; aluop_d = 2'b11; end
      S_IMMWB:   regwrite_d = 1'b1;
      S_JUMP:    begin pcsrc_d = 2'b10; jumpwr_d = 1'b1; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_q     <= '0;
      retired_q  <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      fetch_q    <= 1'b1;
      iord_q     <= 1'b0;
      memread_q  <= 1'b1;
      memwrite_q <= 1'b0;
      jumpwr_q   <= 1'b0;
      branch_q   <= 1'b0;
      branchne_q <= 1'b0;
      pcsrc_q    <= 2'b00;
      aluop_q    <= 2'b00;
      alusrca_q  <= 1'b0;
      alusrcb_q  <= 2'b01;
      regdst_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      retired_q  <= retired_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
      fetch_q    <= fetch_d;
      iord_q     <= iord_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      jumpwr_q   <= jumpwr_d;
      branch_q   <= branch_d;
      branchne_q <= branchne_d;
      pcsrc_q    <= pcsrc_d;
      aluop_q    <= aluop_d;
      alusrca_q  <= alusrca_d;
      alusrcb_q  <= alusrcb_d;
      regdst_q   <= regdst_d;
      memtoreg_q <= memtoreg_d;
      regwrite_q <= regwrite_d;
    end
  end

  // The fetch-time IR/PC load waits on the memory and is held off during reset
  assign IRWrite     = fetch_q && mem_ready && !reset;
  assign PCWrite     = (fetch_q && mem_ready && !reset) || jumpwr_q;
  assign IorD        = iord_q;
  assign MemRead     = memread_q;
  assign MemWrite    = memwrite_q;
  assign Branch      = branch_q;
  assign BranchNe    = branchne_q;
  assign PCSrc       = pcsrc_q;
  assign ALUOp       = aluop_q;
  assign ALUSrcA     = alusrca_q;
  assign ALUSrcB     = alusrcb_q;
  assign RegDst      = regdst_q;
  assign MemtoReg    = memtoreg_q;
  assign RegWrite    = regwrite_q;
  assign state       = state_q;
  assign instr_done  = done_d;
  assign retired     = retired_q;
  assign illegal     = illegal_q;
  assign mem_timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_multicycle_control_fsm                                         |
// | Desc   : Directed vectors with a scoreboard queue and a negedge monitor.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_control_fsm;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010;
  localparam logic [5:0] ORI = 6'b001101, BAD = 6'b111111;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;

  wire [16:0] ctl_a, ctl_b;
  wire [3:0]  st_a, st_b;
  wire        done_a, done_b, ill_a, ill_b, tmo_a, tmo_b;
  wire [31:0] ret_a, ret_b;

  // ctl bit order: IorD MemRead MemWrite IRWrite PCWrite Branch BranchNe PCSrc ALUOp ALUSrcA ALUSrcB RegDst MemtoReg RegWrite
  multicycle_control_fsm dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .IorD(ctl_a[16]), .MemRead(ctl_a[15]), .MemWrite(ctl_a[14]), .IRWrite(ctl_a[13]),
    .PCWrite(ctl_a[12]), .Branch(ctl_a[11]), .BranchNe(ctl_a[10]), .PCSrc(ctl_a[9:8]),
    .ALUOp(ctl_a[7:6]), .ALUSrcA(ctl_a[5]), .ALUSrcB(ctl_a[4:3]), .RegDst(ctl_a[2]),
    .MemtoReg(ctl_a[1]), .RegWrite(ctl_a[0]), .state(st_a), .instr_done(done_a),
    .retired(ret_a), .illegal(ill_a), .mem_timeout(tmo_a)
  );

  multicycle_control_fsm #(.SUPPORT_BNE(1'b0), .MAX_WAIT(4), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .IorD(ctl_b[16]), .MemRead(ctl_b[15]), .MemWrite(ctl_b[14]), .IRWrite(ctl_b[13]),
    .PCWrite(ctl_b[12]), .Branch(ctl_b[11]), .BranchNe(ctl_b[10]), .PCSrc(ctl_b[9:8]),
    .ALUOp(ctl_b[7:6]), .ALUSrcA(ctl_b[5]), .ALUSrcB(ctl_b[4:3]), .RegDst(ctl_b[2]),
    .MemtoReg(ctl_b[1]), .RegWrite(ctl_b[0]), .state(st_b), .instr_done(done_b),
    .retired(ret_b), .illegal(ill_b), .mem_timeout(tmo_b)
  );

  typedef struct {
    int          id;
    logic        sel;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        done;
    logic        ill;
    logic        tmo;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_id  = 0;
  logic sel_g = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control outputs each state is documented to drive; g is the gated fetch load
  function automatic logic [16:0] ctl_of(input logic [3:0] st, input logic [5:0] op, input logic g);
    case (st)
      4'd0:  ctl_of = {1'b0, 1'b1, 1'b0, g, g, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000};
      4'd1:  ctl_of = {7'b0, 2'b00, 2'b00, 1'b0, 2'b11, 3'b000};
      4'd2:  ctl_of = {7'b0, 2'b00, 2'b00, 1'b1, 2'b10, 3'b000};
      4'd3:  ctl_of = {1'b1, 1'b1, 5'b0, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000};
      4'd4:  ctl_of = {7'b0, 2'b00, 2'b00, 1'b0, 2'b00, 3'b011};
      4'd5:  ctl_of = {1'b1, 1'b0, 1'b1, 4'b0, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000};
      4'd6:  ctl_of = {7'b0, 2'b00, 2'b10, 1'b1, 2'b00, 3'b000};
      4'd7:  ctl_of = {7'b0, 2'b00, 2'b00, 1'b0, 2'b00, 3'b101};
      4'd8:  ctl_of = {5'b0, op == BEQ, op == BNE, 2'b01, 2'b01, 1'b1, 2'b00, 3'b000};
      4'd9:  ctl_of = {7'b0, 2'b00, 2'b11, 1'b1, 2'b10, 3'b000};
      4'd10: ctl_of = {7'b0, 2'b00, 2'b00, 1'b0, 2'b00, 3'b001};
      4'd11: ctl_of = {4'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 3'b000};
      default: ctl_of = '0;
    endcase
  endfunction

  task automatic step(input logic r, input logic [5:0] op, input logic mr, input logic [3:0] st,
                      input logic dn, input logic il, input logic tm, input logic [31:0] rt);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = r;
    opcode    = op;
    mem_ready = mr;
    e.id   = n_id;
    e.sel  = sel_g;
    e.st   = st;
    e.ctl  = ctl_of(st, op, mr & ~r);
    e.done = dn;
    e.ill  = il;
    e.tmo  = tm;
    e.ret  = rt;
    sb.push_back(e);
    n_id++;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t        e;
      logic [55:0] act, want;
      e    = sb.pop_front();
      act  = e.sel ? {st_b, ctl_b, done_b, ill_b, tmo_b, ret_b}
                   : {st_a, ctl_a, done_a, ill_a, tmo_a, ret_a};
      want = {e.st, e.ctl, e.done, e.ill, e.tmo, e.ret};
      n_vec++;
      if (act !== want) begin
        n_bad++;
        $display("FAIL vec%0d dut%0d: got st=%0d ctl=%h done=%b ill=%b tmo=%b ret=%0d, want st=%0d ctl=%h done=%b ill=%b tmo=%b ret=%0d",
                 e.id, e.sel, act[55:52], act[51:35], act[34], act[33], act[32], act[31:0],
                 e.st, e.ctl, e.done, e.ill, e.tmo, e.ret);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    opcode    = RT;
    mem_ready = 1'b0;

    // Default instance: reset, lw, R-type, j, ori
    step(1, RT, 1, 0, 0, 0, 0, 0);
    step(0, LW, 1, 0, 0, 0, 0, 0);
    step(0, LW, 1, 1, 0, 0, 0, 0);
    step(0, LW, 1, 2, 0, 0, 0, 0);
    step(0, LW, 1, 3, 0, 0, 0, 0);
    step(0, LW, 1, 4, 1, 0, 0, 0);
    step(0, RT, 1, 0, 0, 0, 0, 1);
    step(0, RT, 1, 1, 0, 0, 0, 1);
    step(0, RT, 1, 6, 0, 0, 0, 1);
    step(0, RT, 1, 7, 1, 0, 0, 1);
    step(0, JMP, 1, 0, 0, 0, 0, 2);
    step(0, JMP, 1, 1, 0, 0, 0, 2);
    step(0, JMP, 1, 11, 1, 0, 0, 2);
    step(0, ORI, 1, 0, 0, 0, 0, 3);
    step(0, ORI, 1, 1, 0, 0, 0, 3);
    step(0, ORI, 1, 9, 0, 0, 0, 3);
    step(0, ORI, 1, 10, 1, 0, 0, 3);
    // sw with three wait states in MEMWR
    step(0, SW, 1, 0, 0, 0, 0, 4);
    step(0, SW, 1, 1, 0, 0, 0, 4);
    step(0, SW, 1, 2, 0, 0, 0, 4);
    step(0, SW, 0, 5, 0, 0, 0, 4);
    step(0, SW, 0, 5, 0, 0, 0, 4);
    step(0, SW, 0, 5, 0, 0, 0, 4);
    step(0, SW, 1, 5, 1, 0, 0, 4);
    // beq after two fetch wait states
    step(0, BEQ, 0, 0, 0, 0, 0, 5);
    step(0, BEQ, 0, 0, 0, 0, 0, 5);
    step(0, BEQ, 1, 0, 0, 0, 0, 5);
    step(0, BEQ, 1, 1, 0, 0, 0, 5);
    step(0, BEQ, 1, 8, 1, 0, 0, 5);
    step(0, BNE, 1, 0, 0, 0, 0, 6);
    step(0, BNE, 1, 1, 0, 0, 0, 6);
    step(0, BNE, 1, 8, 1, 0, 0, 6);
    // Illegal opcode, then lw interrupted by reset while in MEMRD
    step(0, BAD, 1, 0, 0, 0, 0, 7);
    step(0, BAD, 1, 1, 0, 0, 0, 7);
    step(0, BAD, 1, 0, 0, 1, 0, 7);
    step(0, LW, 1, 1, 0, 1, 0, 7);
    step(0, LW, 1, 2, 0, 1, 0, 7);
    step(0, LW, 0, 3, 0, 1, 0, 7);
    step(1, LW, 1, 0, 0, 0, 0, 0);
    step(1, RT, 1, 0, 0, 0, 0, 0);

    // No-bne, MAX_WAIT=4 instance
    sel_g = 1'b1;
    step(0, BNE, 1, 0, 0, 0, 0, 0);
    step(0, BNE, 1, 1, 0, 0, 0, 0);
    step(0, BNE, 1, 0, 0, 1, 0, 0);
    step(0, LW, 1, 1, 0, 1, 0, 0);
    step(0, LW, 1, 2, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, LW, 0, 3, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, LW, 0, 0, 0, 1, 1, 0);
    step(0, LW, 1, 0, 0, 1, 1, 0);
    step(0, LW, 1, 1, 0, 1, 1, 0);
    step(0, LW, 1, 2, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, LW, 0, 3, 0, 1, 1, 0);
    step(0, LW, 1, 3, 0, 1, 1, 0);
    step(0, LW, 1, 4, 1, 1, 1, 0);
    step(0, RT, 1, 0, 0, 1, 1, 1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
